// File: rtl/sad_pkg.sv
// Shared constants, types and the per-tap absolute-difference helper for the SAD matcher.
package sad_pkg;

    localparam int unsigned MAX_PTS  = 127;
    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned SUM_W    = 20;
    localparam int unsigned ABS_W    = SAMPLE_W + 1;
    localparam int unsigned IDX_W    = 7;

    typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

    typedef logic [ABS_W-1:0]           absd_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // |a - b| on one extra bit so the full signed range cannot overflow.
    function automatic absd_t abs_diff(input sample_t a, input sample_t b);
        logic signed [ABS_W-1:0] d;
        d = $signed({a[SAMPLE_W-1], a}) - $signed({b[SAMPLE_W-1], b});
        return d[ABS_W-1] ? absd_t'(-d) : absd_t'(d);
    endfunction

endpackage

// File: rtl/sad_adder_tree.sv
// Pipelined adder tree: MAX_PTS unsigned abs diffs -> SUM_W sum, with enable and valid.
// Build option SAD_PIPE2_EN adds a register between tree levels (one extra cycle).
module sad_adder_tree
    import sad_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  absd_t            i_absd [MAX_PTS],
    output logic             o_valid,
    output logic [SUM_W-1:0] o_sum
);

    localparam int unsigned GRP_SZ  = 16;
    localparam int unsigned NUM_GRP = 8;

    absd_t            w_pad  [NUM_GRP*GRP_SZ];
    logic [SUM_W-1:0] w_part [NUM_GRP];
    logic [SUM_W-1:0] r_part [NUM_GRP];
    logic             r_v1;
    logic [SUM_W-1:0] w_fin;
    logic             w_fin_v;
    logic [SUM_W-1:0] r_sum;
    logic             r_v2;

    for (genvar i = 0; i < NUM_GRP * GRP_SZ; i++) begin : g_pad
        if (i < MAX_PTS) begin : g_tap
            assign w_pad[i] = i_absd[i];
        end else begin : g_zero
            assign w_pad[i] = '0;
        end
    end

    // First level: one partial sum per group of 16 taps.
    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            w_part[g] = '0;
            for (int k = 0; k < GRP_SZ; k++) begin
                w_part[g] = w_part[g] + SUM_W'(w_pad[g*GRP_SZ+k]);
            end
        end
    end

    // Stage 1 register; data only moves with a valid token so the output holds between results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
            for (int g = 0; g < NUM_GRP; g++) r_part[g] <= '0;
        end else if (i_en) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                for (int g = 0; g < NUM_GRP; g++) r_part[g] <= w_part[g];
            end
        end
    end

`ifdef SAD_PIPE2_EN
    logic [SUM_W-1:0] w_mid [2];
    logic [SUM_W-1:0] r_mid [2];
    logic             r_vm;

    // Middle level: two sums of four partials each.
    always_comb begin
        for (int h = 0; h < 2; h++) begin
            w_mid[h] = '0;
            for (int j = 0; j < 4; j++) w_mid[h] = w_mid[h] + r_part[h*4+j];
        end
    end

    // Extra pipeline register between tree levels.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vm     <= 1'b0;
            r_mid[0] <= '0;
            r_mid[1] <= '0;
        end else if (i_en) begin
            r_vm <= r_v1;
            if (r_v1) begin
                r_mid[0] <= w_mid[0];
                r_mid[1] <= w_mid[1];
            end
        end
    end

    // Final level from the middle registers.
    always_comb begin
        w_fin   = r_mid[0] + r_mid[1];
        w_fin_v = r_vm;
    end
`else
    // Final level directly from the partial sums.
    always_comb begin
        w_fin = '0;
        for (int g = 0; g < NUM_GRP; g++) w_fin = w_fin + r_part[g];
        w_fin_v = r_v1;
    end
`endif

    // Stage 2: final sum register feeding the output FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v2  <= 1'b0;
            r_sum <= '0;
        end else if (i_en) begin
            r_v2 <= w_fin_v;
            if (w_fin_v) r_sum <= w_fin;
        end
    end

    assign o_valid = r_v2;
    assign o_sum   = r_sum;

endmodule

// File: rtl/sad.sv
// Streaming sum-of-absolute-differences matcher: loads N reference samples, then emits
// SUM|win[i]-ref[i]| for every accepted input sample. Build option SAD_PIPE2_EN adds one
// cycle of latency inside the adder tree.
module sad
    import sad_pkg::*;
(
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [IDX_W-1:0]    max_points_V,
    input  logic [SAMPLE_W-1:0] ref_points_in_V_dout,
    input  logic                ref_points_in_V_empty_n,
    output logic                ref_points_in_V_read,
    input  logic [SAMPLE_W-1:0] datain_V_dout,
    input  logic                datain_V_empty_n,
    output logic                datain_V_read,
    output logic [SUM_W-1:0]    sumout_V_din,
    input  logic                sumout_V_full_n,
    output logic                sumout_V_write
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_n;
    logic [IDX_W-1:0] r_idx;
    sample_t          r_ref      [MAX_PTS];
    sample_t          r_win      [MAX_PTS];
    sample_t          w_win_nxt  [MAX_PTS];
    absd_t            w_absd     [MAX_PTS];
    logic             w_en;
    logic             w_ref_rd;
    logic             w_dat_rd;
    logic             w_vout;
    logic [SUM_W-1:0] w_sum;

    assign w_en = sumout_V_full_n;

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_ready    = 1'b0;
        w_ref_rd    = 1'b0;
        w_dat_rd    = 1'b0;
        unique case (r_state)
            StIdle: begin
                ap_idle = 1'b1;
                if (ap_start) w_state_nxt = (max_points_V == '0) ? StStream : StLoad;
            end
            StLoad: begin
                w_ref_rd = ref_points_in_V_empty_n;
                if (w_ref_rd && (r_idx + IDX_W'(1) == r_n)) begin
                    ap_ready    = 1'b1;
                    w_state_nxt = StStream;
                end
            end
            StStream: w_dat_rd = datain_V_empty_n & w_en;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // Window after a shift-in: taps below N-1 move down, tap N-1 takes the new sample.
    always_comb begin
        for (int i = 0; i < int'(MAX_PTS) - 1; i++) begin
            if (i < int'(r_n) - 1)       w_win_nxt[i] = r_win[i+1];
            else if (i == int'(r_n) - 1) w_win_nxt[i] = datain_V_dout;
            else                         w_win_nxt[i] = r_win[i];
        end
        w_win_nxt[MAX_PTS-1] = (int'(r_n) == int'(MAX_PTS)) ? datain_V_dout
                                                             : r_win[MAX_PTS-1];
    end

    // Per-tap abs diff on the post-shift window so the tree sees it in the read cycle.
    always_comb begin
        for (int i = 0; i < int'(MAX_PTS); i++) begin
            w_absd[i] = (i < int'(r_n)) ? abs_diff(w_win_nxt[i], r_ref[i]) : '0;
        end
    end

    // State, reference storage and window registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= StIdle;
            r_n     <= '0;
            r_idx   <= '0;
            for (int i = 0; i < int'(MAX_PTS); i++) begin
                r_ref[i] <= '0;
                r_win[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && ap_start) begin
                r_n   <= max_points_V;
                r_idx <= '0;
                for (int i = 0; i < int'(MAX_PTS); i++) r_win[i] <= '0;
            end
            if (w_ref_rd) begin
                r_ref[r_idx] <= ref_points_in_V_dout;
                r_idx        <= r_idx + IDX_W'(1);
            end
            if (w_dat_rd) begin
                for (int i = 0; i < int'(MAX_PTS); i++) r_win[i] <= w_win_nxt[i];
            end
        end
    end

    sad_adder_tree u_tree (
        .i_clk   (ap_clk),
        .i_rst   (ap_rst),
        .i_en    (w_en),
        .i_valid (w_dat_rd),
        .i_absd  (w_absd),
        .o_valid (w_vout),
        .o_sum   (w_sum)
    );

    assign ap_done              = 1'b0;
    assign ref_points_in_V_read = w_ref_rd;
    assign datain_V_read        = w_dat_rd;
    assign sumout_V_din         = w_sum;
    assign sumout_V_write       = w_vout & sumout_V_full_n;

endmodule

// File: tb/tb_sad.sv
// Directed bench for the SAD matcher: FIFO models, cycle-level event capture, hand-computed sums.
module tb_sad;

`ifdef SAD_PIPE2_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [6:0]  max_points_V;
    logic [9:0]  ref_points_in_V_dout;
    logic        ref_points_in_V_empty_n;
    logic        ref_points_in_V_read;
    logic [9:0]  datain_V_dout;
    logic        datain_V_empty_n;
    logic        datain_V_read;
    logic [19:0] sumout_V_din;
    logic        sumout_V_full_n;
    logic        sumout_V_write;

    always #5 ap_clk = ~ap_clk;

    sad dut (
        .ap_clk                  (ap_clk),
        .ap_rst                  (ap_rst),
        .ap_start                (ap_start),
        .ap_done                 (ap_done),
        .ap_idle                 (ap_idle),
        .ap_ready                (ap_ready),
        .max_points_V            (max_points_V),
        .ref_points_in_V_dout    (ref_points_in_V_dout),
        .ref_points_in_V_empty_n (ref_points_in_V_empty_n),
        .ref_points_in_V_read    (ref_points_in_V_read),
        .datain_V_dout           (datain_V_dout),
        .datain_V_empty_n        (datain_V_empty_n),
        .datain_V_read           (datain_V_read),
        .sumout_V_din            (sumout_V_din),
        .sumout_V_full_n         (sumout_V_full_n),
        .sumout_V_write          (sumout_V_write)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [9:0] ref_q [$];
    logic [9:0] dat_q [$];
    int         wr_q  [$];
    int         wrc_q [$];
    int         rdc_q [$];
    int         n_ready, n_refrd, n_rdempty, rdy_cyc, lastref_cyc;
    bit         toggle = 1'b0;
    bit         phase = 1'b0;
    bit         full_v = 1'b1;
    logic       s_rref, s_rdat, s_wr, s_idle;
    int         s_din;
    int         din0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ref_points_in_V_empty_n = (ref_q.size() > 0) && (!toggle || phase);
        ref_points_in_V_dout    = (ref_q.size() > 0) ? ref_q[0] : 10'd0;
        datain_V_empty_n        = (dat_q.size() > 0);
        datain_V_dout           = (dat_q.size() > 0) ? dat_q[0] : 10'd0;
        sumout_V_full_n         = full_v;
    endtask

    // One clock: sample DUT at the falling edge, then pop consumed FIFO entries after the rise.
    task automatic tick();
        @(negedge ap_clk);
        s_rref = ref_points_in_V_read;
        s_rdat = datain_V_read;
        s_wr   = sumout_V_write;
        s_din  = int'(sumout_V_din);
        s_idle = ap_idle;
        if (s_wr) begin
            wr_q.push_back(s_din);
            wrc_q.push_back(cyc);
        end
        if (s_rdat) rdc_q.push_back(cyc);
        if (ap_ready) begin
            n_ready++;
            rdy_cyc = cyc;
        end
        if (s_rref) begin
            n_refrd++;
            lastref_cyc = cyc;
            if (!ref_points_in_V_empty_n) n_rdempty++;
        end
        @(posedge ap_clk);
        #1;
        cyc++;
        if (s_rref && ref_q.size() > 0) void'(ref_q.pop_front());
        if (s_rdat && dat_q.size() > 0) void'(dat_q.pop_front());
        phase = ~phase;
        drive();
    endtask

    task automatic clr();
        wr_q.delete();
        wrc_q.delete();
        rdc_q.delete();
        n_ready   = 0;
        n_refrd   = 0;
        n_rdempty = 0;
    endtask

    task automatic do_reset();
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        ref_q.delete();
        dat_q.delete();
        drive();
        tick();
        tick();
        ap_rst = 1'b0;
        drive();
        clr();
    endtask

    task automatic start(input int n);
        max_points_V = 7'(n);
        ap_start     = 1'b1;
        drive();
        tick();
        ap_start = 1'b0;
    endtask

    task automatic wait_load();
        int k = 0;
        while (n_ready == 0 && k < 400) begin
            tick();
            k++;
        end
        chk("load_ready_seen", n_ready, 1);
    endtask

    task automatic run_wr(input int n, input int budget);
        int k = 0;
        while (wr_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("write_count", wr_q.size(), n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp2 [4];
        int exp5 [6];
        int e;
        exp2 = '{90, 70, 40, 0};
        exp5 = '{90, 70, 40, 0, 40, 80};
        max_points_V = '0;

        // 1: reset state after two reset cycles
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        drive();
        tick();
        tick();
        @(negedge ap_clk);
        chk("rst_idle", int'(ap_idle), 1);
        chk("rst_ready", int'(ap_ready), 0);
        chk("rst_done", int'(ap_done), 0);
        chk("rst_refrd", int'(ref_points_in_V_read), 0);
        chk("rst_datrd", int'(datain_V_read), 0);
        chk("rst_write", int'(sumout_V_write), 0);
        chk("rst_din", int'(sumout_V_din), 0);
        @(posedge ap_clk);
        #1;
        cyc++;

        // 2: N=4 basic streaming with latency check
        do_reset();
        ref_q = '{10'd10, 10'd20, 10'd30, 10'd40};
        start(4);
        wait_load();
        dat_q = '{10'd10, 10'd20, 10'd30, 10'd40};
        drive();
        run_wr(4, 40);
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            chk("t2_sum", wr_q[i], exp2[i]);
            if (i < rdc_q.size()) chk("t2_latency", wrc_q[i] - rdc_q[i], LAT);
        end

        // 3: N=127 extremes; filled taps give 1023, empty taps |0-(-512)| = 512
        do_reset();
        for (int i = 0; i < 127; i++) ref_q.push_back(10'h200);
        start(127);
        wait_load();
        for (int i = 0; i < 130; i++) dat_q.push_back(10'd511);
        drive();
        run_wr(130, 400);
        for (int k = 1; k <= 130 && k <= wr_q.size(); k++) begin
            e = (k >= 127) ? 129921 : k * 1023 + (127 - k) * 512;
            chk("t3_sum", wr_q[k-1], e);
        end

        // 4: reference FIFO empty_n toggling during load
        do_reset();
        toggle = 1'b1;
        ref_q  = '{10'd5, 10'h3fb, 10'd7};
        start(3);
        wait_load();
        toggle = 1'b0;
        chk("t4_read_when_empty", n_rdempty, 0);
        chk("t4_ref_reads", n_refrd, 3);
        chk("t4_ready_at_last_read", rdy_cyc, lastref_cyc);
        dat_q = '{10'd1, 10'd2, 10'd3};
        drive();
        run_wr(3, 40);
        chk("t4_ready_once", n_ready, 1);
        if (wr_q.size() >= 3) begin
            chk("t4_sum0", wr_q[0], 16);
            chk("t4_sum1", wr_q[1], 16);
            chk("t4_sum2", wr_q[2], 15);
        end

        // 5: output FIFO full for 3 cycles mid-stream
        do_reset();
        ref_q = '{10'd10, 10'd20, 10'd30, 10'd40};
        start(4);
        wait_load();
        dat_q = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd60};
        drive();
        tick();
        tick();
        full_v = 1'b0;
        drive();
        din0 = (LAT == 2) ? 90 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_frozen_read", int'(s_rdat), 0);
            chk("t5_frozen_write", int'(s_wr), 0);
            chk("t5_frozen_din", s_din, din0);
        end
        full_v = 1'b1;
        drive();
        tick();
        chk("t5_resume_din", s_din, din0);
        run_wr(6, 60);
        for (int i = 0; i < 6 && i < wr_q.size(); i++) chk("t5_sum", wr_q[i], exp5[i]);

        // 6: reset with a result in flight, then restart with N=2
        dat_q = '{10'd70};
        drive();
        tick();
        ap_rst = 1'b1;
        drive();
        tick();
        ap_rst = 1'b0;
        ref_q.delete();
        dat_q.delete();
        clr();
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_write_after_rst", int'(s_wr), 0);
            chk("t6_idle_after_rst", int'(s_idle), 1);
        end
        ref_q = '{10'd100, 10'h39c};
        start(2);
        wait_load();
        dat_q = '{10'd7, 10'd9};
        drive();
        run_wr(2, 30);
        if (wr_q.size() >= 2) begin
            chk("t6_sum0", wr_q[0], 207);
            chk("t6_sum1", wr_q[1], 202);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
